// File: rtl/monkey_hit_detector_pkg.sv
// -----------------------------------------------------------------------------
// monkey_hit_detector_pkg
// Shared definitions for the monkey hit detector:
//   - state_e      : frame FSM states (IDLE, ARMED, RUN)
//   - EDGE_*       : bit positions inside the 4-bit edge-hit code
//   - DEF_*        : default geometry / hysteresis parameters
//   - sat_inc16    : saturating 16-bit increment used by the pixel counter
// -----------------------------------------------------------------------------
package monkey_hit_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Edge code bit positions
    localparam int EDGE_TOP    = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 2;
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_COUNT  = 4;

    // Default parameters
    localparam int DEF_OBJECT_WIDTH   = 64;
    localparam int DEF_OBJECT_HEIGHT  = 64;
    localparam int DEF_EDGE_MARGIN    = 4;
    localparam int DEF_FOOT_ROWS      = 4;
    localparam int DEF_RELEASE_FRAMES = 2;

    localparam int OFFSET_WIDTH = 11;
    localparam int COUNT_WIDTH  = 16;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = 16'hFFFF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc16(input logic [COUNT_WIDTH-1:0] value);
        return (value == COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/monkey_hit_detector_hit_edge_classify.sv
// -----------------------------------------------------------------------------
// hit_edge_classify
// Purely combinational classifier: turns the sprite-relative pixel offsets of
// a block hit into an edge mask and a foot flag. Outputs are forced to zero
// when hit is low, so offsets are don't-care outside of hits. Offsets outside
// the sprite are still classified by plain unsigned compares.
// Ports:
//   hit       in   pixel is a monkey/block overlap
//   offset_x  in   11-bit unsigned X offset inside the sprite
//   offset_y  in   11-bit unsigned Y offset inside the sprite
//   edge_mask out  [0]=top [1]=right [2]=bottom [3]=left
//   foot      out  pixel lies in the bottom FOOT_ROWS rows
// -----------------------------------------------------------------------------
module hit_edge_classify
    import monkey_hit_detector_pkg::*;
#(
    parameter int OBJECT_WIDTH  = DEF_OBJECT_WIDTH,
    parameter int OBJECT_HEIGHT = DEF_OBJECT_HEIGHT,
    parameter int EDGE_MARGIN   = DEF_EDGE_MARGIN,
    parameter int FOOT_ROWS     = DEF_FOOT_ROWS
) (
    input  logic                    hit,
    input  logic [OFFSET_WIDTH-1:0] offset_x,
    input  logic [OFFSET_WIDTH-1:0] offset_y,
    output logic [EDGE_COUNT-1:0]   edge_mask,
    output logic                    foot
);

    localparam logic [OFFSET_WIDTH-1:0] TOP_LIMIT    = OFFSET_WIDTH'(EDGE_MARGIN);
    localparam logic [OFFSET_WIDTH-1:0] LEFT_LIMIT   = OFFSET_WIDTH'(EDGE_MARGIN);
    localparam logic [OFFSET_WIDTH-1:0] BOTTOM_LIMIT = OFFSET_WIDTH'(OBJECT_HEIGHT - EDGE_MARGIN);
    localparam logic [OFFSET_WIDTH-1:0] RIGHT_LIMIT  = OFFSET_WIDTH'(OBJECT_WIDTH - EDGE_MARGIN);
    localparam logic [OFFSET_WIDTH-1:0] FOOT_LIMIT   = OFFSET_WIDTH'(OBJECT_HEIGHT - FOOT_ROWS);

    always_comb begin
        edge_mask              = '0;
        edge_mask[EDGE_TOP]    = hit && (offset_y <  TOP_LIMIT);
        edge_mask[EDGE_RIGHT]  = hit && (offset_x >= RIGHT_LIMIT);
        edge_mask[EDGE_BOTTOM] = hit && (offset_y >= BOTTOM_LIMIT);
        edge_mask[EDGE_LEFT]   = hit && (offset_x <  LEFT_LIMIT);
        foot                   = hit && (offset_y >= FOOT_LIMIT);
    end

endmodule

// File: rtl/monkey_hit_detector.sv
// -----------------------------------------------------------------------------
// monkey_hit_detector
// Accumulates monkey/block and monkey/rope overlaps over one video frame and
// publishes a per-frame summary at each startOfFrame. onBlock follows the foot
// contact with a release hysteresis of RELEASE_FRAMES footless frames.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high
//   startOfFrame  in   one-clk pulse per frame
//   monkeyDR      in   monkey sprite drawing request
//   blockDR       in   block drawing request
//   ropeDR        in   rope drawing request
//   offsetX/Y     in   11-bit pixel offsets inside the monkey sprite
//   collision     out  any monkey/block overlap last frame
//   onBlock       out  feet on block with release hysteresis
//   onRope        out  monkey/rope overlap last frame
//   HitEdgeCode   out  [0]=top [1]=right [2]=bottom [3]=left, last frame
//   hitPixelCount out  saturating overlap pixel count, last frame
// -----------------------------------------------------------------------------
module monkey_hit_detector
    import monkey_hit_detector_pkg::*;
#(
    parameter int OBJECT_WIDTH   = DEF_OBJECT_WIDTH,
    parameter int OBJECT_HEIGHT  = DEF_OBJECT_HEIGHT,
    parameter int EDGE_MARGIN    = DEF_EDGE_MARGIN,
    parameter int FOOT_ROWS      = DEF_FOOT_ROWS,
    parameter int RELEASE_FRAMES = DEF_RELEASE_FRAMES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    monkeyDR,
    input  logic                    blockDR,
    input  logic                    ropeDR,
    input  logic [OFFSET_WIDTH-1:0] offsetX,
    input  logic [OFFSET_WIDTH-1:0] offsetY,
    output logic                    collision,
    output logic                    onBlock,
    output logic                    onRope,
    output logic [EDGE_COUNT-1:0]   HitEdgeCode,
    output logic [COUNT_WIDTH-1:0]  hitPixelCount
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ARMED = ST_ARMED;
    localparam logic [1:0] RUN   = ST_RUN;

    // Release counter only needs to reach RELEASE_FRAMES; +2 keeps width >= 1.
    localparam int                  REL_WIDTH = $clog2(RELEASE_FRAMES + 2);
    localparam logic [REL_WIDTH-1:0] REL_LIMIT = REL_WIDTH'(RELEASE_FRAMES);

    logic                   block_hit;
    logic                   rope_hit;
    logic [EDGE_COUNT-1:0]  pixel_edges;
    logic                   pixel_foot;

    logic [1:0]             state_reg;
    logic [EDGE_COUNT-1:0]  edge_acc_reg;
    logic                   foot_acc_reg;
    logic                   rope_acc_reg;
    logic                   coll_acc_reg;
    logic [COUNT_WIDTH-1:0] count_acc_reg;
    logic [REL_WIDTH-1:0]   release_cnt_reg;
    logic [REL_WIDTH-1:0]   release_cnt_next;

    logic                   collision_reg;
    logic                   on_block_reg;
    logic                   on_rope_reg;
    logic [EDGE_COUNT-1:0]  edge_code_reg;
    logic [COUNT_WIDTH-1:0] pixel_count_reg;

    assign block_hit = monkeyDR && blockDR;
    assign rope_hit  = monkeyDR && ropeDR;

    hit_edge_classify #(
        .OBJECT_WIDTH  (OBJECT_WIDTH),
        .OBJECT_HEIGHT (OBJECT_HEIGHT),
        .EDGE_MARGIN   (EDGE_MARGIN),
        .FOOT_ROWS     (FOOT_ROWS)
    ) u_classify (
        .hit       (block_hit),
        .offset_x  (offsetX),
        .offset_y  (offsetY),
        .edge_mask (pixel_edges),
        .foot      (pixel_foot)
    );

    // Footless-frame count after this publish, sticking at the limit.
    assign release_cnt_next = (release_cnt_reg >= REL_LIMIT) ? release_cnt_reg
                                                             : release_cnt_reg + REL_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            edge_acc_reg    <= '0;
            foot_acc_reg    <= 1'b0;
            rope_acc_reg    <= 1'b0;
            coll_acc_reg    <= 1'b0;
            count_acc_reg   <= '0;
            release_cnt_reg <= '0;
            collision_reg   <= 1'b0;
            on_block_reg    <= 1'b0;
            on_rope_reg     <= 1'b0;
            edge_code_reg   <= '0;
            pixel_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (startOfFrame) begin
                        // The SOF pixel is the first pixel of the ARMED frame.
                        state_reg     <= ARMED;
                        edge_acc_reg  <= pixel_edges;
                        foot_acc_reg  <= pixel_foot;
                        rope_acc_reg  <= rope_hit;
                        coll_acc_reg  <= block_hit;
                        count_acc_reg <= {{(COUNT_WIDTH-1){1'b0}}, block_hit};
                    end else begin
                        edge_acc_reg  <= '0;
                        foot_acc_reg  <= 1'b0;
                        rope_acc_reg  <= 1'b0;
                        coll_acc_reg  <= 1'b0;
                        count_acc_reg <= '0;
                    end
                end
                ARMED, RUN: begin
                    if (startOfFrame) begin
                        state_reg       <= RUN;
                        // Publish the finished frame; the SOF pixel is excluded.
                        collision_reg   <= coll_acc_reg;
                        on_rope_reg     <= rope_acc_reg;
                        edge_code_reg   <= edge_acc_reg;
                        pixel_count_reg <= count_acc_reg;
                        if (foot_acc_reg) begin
                            on_block_reg    <= 1'b1;
                            release_cnt_reg <= '0;
                        end else begin
                            release_cnt_reg <= release_cnt_next;
                            if (release_cnt_next >= REL_LIMIT) begin
                                on_block_reg <= 1'b0;
                            end
                        end
                        // Start the new frame with this pixel's contribution.
                        edge_acc_reg  <= pixel_edges;
                        foot_acc_reg  <= pixel_foot;
                        rope_acc_reg  <= rope_hit;
                        coll_acc_reg  <= block_hit;
                        count_acc_reg <= {{(COUNT_WIDTH-1){1'b0}}, block_hit};
                    end else begin
                        edge_acc_reg <= edge_acc_reg | pixel_edges;
                        foot_acc_reg <= foot_acc_reg | pixel_foot;
                        rope_acc_reg <= rope_acc_reg | rope_hit;
                        coll_acc_reg <= coll_acc_reg | block_hit;
                        if (block_hit) begin
                            count_acc_reg <= sat_inc16(count_acc_reg);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign collision     = collision_reg;
    assign onBlock       = on_block_reg;
    assign onRope        = on_rope_reg;
    assign HitEdgeCode   = edge_code_reg;
    assign hitPixelCount = pixel_count_reg;

endmodule

// File: tb/tb_monkey_hit_detector.sv
// -----------------------------------------------------------------------------
// tb_monkey_hit_detector
// Self-checking bench: directed scenarios plus randomized frames, compared
// against a frame-level behavioural model of the hit detector.
// -----------------------------------------------------------------------------
module tb_monkey_hit_detector;

    localparam int OW  = 64;
    localparam int OH  = 64;
    localparam int EM  = 4;
    localparam int FR  = 4;
    localparam int REL = 2;

    logic        clk;
    logic        reset;
    logic        startOfFrame;
    logic        monkeyDR;
    logic        blockDR;
    logic        ropeDR;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        collision;
    logic        onBlock;
    logic        onRope;
    logic [3:0]  HitEdgeCode;
    logic [15:0] hitPixelCount;

    monkey_hit_detector dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .monkeyDR      (monkeyDR),
        .blockDR       (blockDR),
        .ropeDR        (ropeDR),
        .offsetX       (offsetX),
        .offsetY       (offsetY),
        .collision     (collision),
        .onBlock       (onBlock),
        .onRope        (onRope),
        .HitEdgeCode   (HitEdgeCode),
        .hitPixelCount (hitPixelCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level model state
    bit          md_started;
    int          md_hits;
    bit [3:0]    md_edge;
    bit          md_foot;
    bit          md_rope;
    bit          foot_hist[$];
    bit          exp_coll;
    bit          exp_onblock;
    bit          exp_rope;
    bit [3:0]    exp_edge;
    bit [15:0]   exp_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_started = 0;
        md_hits = 0; md_edge = 0; md_foot = 0; md_rope = 0;
        foot_hist.delete();
        exp_coll = 0; exp_onblock = 0; exp_rope = 0; exp_edge = 0; exp_cnt = 0;
    endtask

    task automatic model_publish();
        exp_coll = (md_hits > 0);
        exp_rope = md_rope;
        exp_edge = md_edge;
        exp_cnt  = (md_hits > 65535) ? 16'hFFFF : 16'(md_hits);
        foot_hist.push_back(md_foot);
        // onBlock is high iff any of the last REL published frames had feet.
        exp_onblock = 0;
        for (int i = 0; i < REL; i++) begin
            int idx = foot_hist.size() - 1 - i;
            if (idx >= 0 && foot_hist[idx]) exp_onblock = 1;
        end
    endtask

    task automatic model_clock(input bit sof, input bit m, input bit b, input bit r,
                               input logic [10:0] x, input logic [10:0] y);
        int xi = int'(x);
        int yi = int'(y);
        if (sof) begin
            if (md_started) model_publish();
            md_started = 1;
            md_hits = 0; md_edge = 0; md_foot = 0; md_rope = 0;
        end
        if (m && b) begin
            md_hits++;
            if (yi < EM)      md_edge[0] = 1;
            if (xi >= OW-EM)  md_edge[1] = 1;
            if (yi >= OH-EM)  md_edge[2] = 1;
            if (xi < EM)      md_edge[3] = 1;
            if (yi >= OH-FR)  md_foot    = 1;
        end
        if (m && r) md_rope = 1;
    endtask

    task automatic check_outputs();
        check_val("collision", collision, exp_coll);
        check_val("onBlock", onBlock, exp_onblock);
        check_val("onRope", onRope, exp_rope);
        check_val("HitEdgeCode", HitEdgeCode, exp_edge);
        check_val("hitPixelCount", hitPixelCount, exp_cnt);
    endtask

    // One clock: drive inputs, clock edge, update model, sample 1 ns later.
    task automatic step(input bit sof, input bit m, input bit b, input bit r,
                        input int x, input int y, input bit chk);
        startOfFrame = sof; monkeyDR = m; blockDR = b; ropeDR = r;
        offsetX = 11'(x); offsetY = 11'(y);
        @(posedge clk);
        model_clock(sof, m, b, r, 11'(x), 11'(y));
        #1;
        if (chk) check_outputs();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic apply_reset(input bit check_async);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        if (check_async) begin
            check_outputs();
            check_val("reset_state_idle", 32'(dut.state_reg), 32'd0);
        end
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        startOfFrame = 0; monkeyDR = 0; blockDR = 0; ropeDR = 0;
        offsetX = 0; offsetY = 0;
        model_reset();
        #3;
        check_outputs();
        #9;
        reset = 1'b0;

        // Single bottom-left hit between two SOFs
        step(1, 0, 0, 0, 0, 0, 1);
        idle_steps(3);
        step(0, 1, 1, 0, 0, 63, 1);
        idle_steps(3);
        step(1, 0, 0, 0, 0, 0, 1);
        check_val("single_hit_edge", HitEdgeCode, 4'b1100);
        check_val("single_hit_coll", collision, 1'b1);
        check_val("single_hit_onblock", onBlock, 1'b1);
        check_val("single_hit_count", hitPixelCount, 16'd1);

        // Two footless frames: onBlock holds one frame, then drops
        idle_steps(5);
        step(1, 0, 0, 0, 0, 0, 1);
        check_val("release_hold", onBlock, 1'b1);
        idle_steps(5);
        step(1, 0, 0, 0, 0, 0, 1);
        check_val("release_drop", onBlock, 1'b0);

        // Hit coincident with SOF belongs to the new frame
        idle_steps(4);
        step(1, 1, 1, 0, 32, 0, 1);
        check_val("sof_hit_excluded", hitPixelCount, 16'd0);
        idle_steps(4);
        step(1, 0, 0, 0, 0, 0, 1);
        check_val("sof_hit_edge", HitEdgeCode, 4'b0001);
        check_val("sof_hit_count", hitPixelCount, 16'd1);

        // Hits before first SOF after reset are discarded
        apply_reset(0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, 63, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        idle_steps(6);
        step(1, 0, 0, 0, 0, 0, 1);
        check_val("pre_sof_coll", collision, 1'b0);
        check_val("pre_sof_count", hitPixelCount, 16'd0);
        check_val("pre_sof_onblock", onBlock, 1'b0);

        // Saturating pixel counter
        for (int i = 0; i < 70000; i++) step(0, 1, 1, 0, 20, 20, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        check_val("saturate_count", hitPixelCount, 16'hFFFF);

        // Rope-only overlap, plus blockDR without monkeyDR at wild offsets
        step(0, 1, 0, 1, 10, 10, 1);
        step(0, 0, 1, 0, 2047, 2047, 1);
        step(0, 1, 0, 1, 1500, 3, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        check_val("rope_only_rope", onRope, 1'b1);
        check_val("rope_only_coll", collision, 1'b0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            int len  = $urandom_range(6, 40);
            int kind = $urandom_range(0, 2);
            for (int c = 0; c < len; c++) begin
                bit m  = ($urandom_range(0, 3) != 0);
                bit b  = (kind != 0) && ($urandom_range(0, 2) == 0);
                bit r  = ($urandom_range(0, 5) == 0);
                int x  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 63);
                int y  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 63);
                step(c == 0, m, b, r, x, y, 1);
            end
            if (f == 25) begin
                // Mid-frame reset discards the partial frame
                apply_reset(1);
            end
        end

        // Asynchronous reset mid-RUN with live outputs
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 1, 62, 62, 1);
        step(0, 1, 1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        check_val("pre_reset_coll", collision, 1'b1);
        step(0, 1, 1, 0, 5, 5, 1);
        apply_reset(1);
        check_val("async_reset_count", hitPixelCount, 16'd0);
        check_val("async_reset_onblock", onBlock, 1'b0);
        idle_steps(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
